// File: rtl/lpm_pipereg_pkg.sv
// Shared definitions for lpm_pipereg.
//   clog2    : ceiling log2, sizes the usedw occupancy counter
//   PARITY_W : width of the per-stage parity bit (LPM_PIPEREG_PARITY_EN builds)
package lpm_pipereg_pkg;

    localparam int unsigned PARITY_W = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lpm_pipereg_stage.sv
// One register stage of lpm_pipereg: a data word plus its valid flag.
// Ports:
//   clock    rising-edge clock
//   aclr     async active-high clear: vld=0, dat=CLR_VAL
//   sclr     sync flush: vld=0, dat held
//   load     stage may take its source this edge (ready chain bit)
//   src_dat  word from the upstream stage (or the block input)
//   src_vld  valid flag from the upstream stage (or in_valid)
//   dat/vld  stage contents
module lpm_pipereg_stage #(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clock,
    input  logic         aclr,
    input  logic         sclr,
    input  logic         load,
    input  logic [W-1:0] src_dat,
    input  logic         src_vld,
    output logic [W-1:0] dat,
    output logic         vld
);

    // The data word only moves when a valid word arrives, so a bubble passing
    // through leaves the previous contents in place (q holds when empty).
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            dat <= CLR_VAL;
            vld <= 1'b0;
        end else if (sclr) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= src_vld;
            if (src_vld) begin
                dat <= src_dat;
            end
        end
    end

endmodule

// File: rtl/lpm_pipereg.sv
// lpm_pipereg: clocked LPM pipeline register, lpm_depth stages of lpm_width
// bits with valid/ready flow control and bubble collapse.
// Optional macro LPM_PIPEREG_PARITY_EN adds a stored even-parity bit per stage
// and the perr output.
// Ports:
//   clock      rising-edge clock
//   aclr       async active-high clear (tie low when unused)
//   sclr       synchronous flush, drops all valid words (tie low when unused)
//   data       input word
//   in_valid   data is valid this cycle
//   in_ready   block accepts data this cycle (combinational)
//   q          output word, last-stage data
//   out_valid  q is valid
//   out_ready  consumer accepts q this cycle (tie high when unused)
//   usedw      number of valid stages (registered)
//   perr       parity mismatch on the output word (parity builds only)
module lpm_pipereg
    import lpm_pipereg_pkg::*;
#(
    parameter              lpm_type   = "lpm_pipereg",
    parameter int unsigned lpm_width  = 8,
    parameter int unsigned lpm_depth  = 3,
    parameter int          lpm_avalue = 0,
    parameter              lpm_hint   = "UNUSED"
) (
    input  logic                                 clock,
    input  logic                                 aclr,
    input  logic                                 sclr,
    input  logic [lpm_width-1:0]                 data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [lpm_width-1:0]                 q,
    output logic                                 out_valid,
    input  logic                                 out_ready,
`ifdef LPM_PIPEREG_PARITY_EN
    output logic                                 perr,
`endif
    output logic [clog2(lpm_depth+1)-1:0]        usedw
);

    localparam int unsigned DW      = lpm_width;
    localparam int unsigned USEDW_W = clog2(lpm_depth + 1);
    localparam int unsigned LAST    = lpm_depth - 1;
    localparam logic [DW-1:0] AVAL  = DW'(lpm_avalue);
`ifdef LPM_PIPEREG_PARITY_EN
    localparam int unsigned   ST_W   = DW + PARITY_W;
    localparam logic [ST_W-1:0] ST_CLR = {^AVAL, AVAL};
`else
    localparam int unsigned   ST_W   = DW;
    localparam logic [ST_W-1:0] ST_CLR = AVAL;
`endif

    // Elaboration-time sanity on the configuration and tag parameters.
    if (lpm_width < 1 || lpm_depth < 1 || $bits(lpm_type) == 0 || $bits(lpm_hint) == 0)
    begin : g_bad_param
        $error("lpm_pipereg: lpm_width and lpm_depth must be >= 1");
    end

    logic [ST_W-1:0]      st_dat [lpm_depth];
    logic [lpm_depth-1:0] st_vld;
    logic [lpm_depth-1:0] rdy;
    logic [ST_W-1:0]      s0_dat;
    logic                 accept;
    logic                 emit;

    // Word entering S0, with its parity bit when enabled.
`ifdef LPM_PIPEREG_PARITY_EN
    assign s0_dat = {^data, data};
`else
    assign s0_dat = data;
`endif

    // Ready chain from the output side: an empty stage always accepts, so
    // upstream words keep advancing into bubbles while the output stalls.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = out_ready;
        for (int unsigned i = lpm_depth; i > 0; i--) begin
            chain      = ~st_vld[i-1] | chain;
            rdy[i-1]   = chain;
        end
    end

    // Stage chain S0 (input side) .. S[LAST] (output side).
    for (genvar i = 0; i < int'(lpm_depth); i++) begin : g_stage
        logic [ST_W-1:0] src_dat;
        logic            src_vld;

        if (i == 0) begin : g_src_in
            assign src_dat = s0_dat;
            assign src_vld = in_valid;
        end else begin : g_src_prev
            assign src_dat = st_dat[i-1];
            assign src_vld = st_vld[i-1];
        end

        lpm_pipereg_stage #(
            .W       (ST_W),
            .CLR_VAL (ST_CLR)
        ) u_stage (
            .clock   (clock),
            .aclr    (aclr),
            .sclr    (sclr),
            .load    (rdy[i]),
            .src_dat (src_dat),
            .src_vld (src_vld),
            .dat     (st_dat[i]),
            .vld     (st_vld[i])
        );
    end

    assign in_ready  = rdy[0] & ~aclr;
    assign q         = st_dat[LAST][DW-1:0];
    assign out_valid = st_vld[LAST];
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

`ifdef LPM_PIPEREG_PARITY_EN
    // Recomputed parity of the output word against the bit stored at S0.
    assign perr = out_valid & ((^q) != st_dat[LAST][DW]);
`endif

    // Occupancy counter; a simultaneous accept and emit leaves it unchanged.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            usedw <= '0;
        end else if (sclr) begin
            usedw <= '0;
        end else if (accept && !emit) begin
            usedw <= usedw + USEDW_W'(1);
        end else if (emit && !accept) begin
            usedw <= usedw - USEDW_W'(1);
        end
    end

endmodule
